// File: rtl/fetch_pkg.sv
// Shared constants for the fetch queue: packet geometry and the
// {mask, addr, data} layout of one storage entry.
package fetch_pkg;

   localparam int unsigned FQ_DATA_W = 64;
   localparam int unsigned FQ_ADDR_W = 10;
   localparam int unsigned FQ_SLOTS  = 2;
   localparam int unsigned FQ_INSN_W = FQ_DATA_W / FQ_SLOTS;

   // Entry layout, LSB first: data, then addr, then mask.
   function automatic int unsigned fq_data_lsb();
      return 0;
   endfunction

   function automatic int unsigned fq_addr_lsb(input int unsigned data_w);
      return data_w;
   endfunction

   function automatic int unsigned fq_mask_lsb(input int unsigned data_w,
                                               input int unsigned addr_w);
      return data_w + addr_w;
   endfunction

   function automatic int unsigned fq_entry_w(input int unsigned data_w,
                                              input int unsigned addr_w);
      return data_w + addr_w + FQ_SLOTS;
   endfunction

endpackage

// File: rtl/fq_storage.sv
// Fetch queue entry array: one synchronous write port, one asynchronous
// read port, no reset on the contents.
module fq_storage #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 76
) (
   input  logic                     clock_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clock_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Fetch packet queue between the instruction memory read port and decode,
// with early memory stall, sticky overflow flag and redirect flush.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = FQ_DATA_W,
   parameter int unsigned ADDR_W = FQ_ADDR_W
) (
   input  logic                     clock_i,
   input  logic                     reset_ni,
   input  logic                     enq_valid_i,
   input  logic [DATA_W-1:0]        enq_data_i,
   input  logic [ADDR_W-1:0]        enq_addr_i,
   input  logic [1:0]               enq_mask_i,
   output logic                     enq_ready_o,
   output logic                     stall_o,
   output logic                     deq_valid_o,
   output logic [DATA_W-1:0]        deq_data_o,
   output logic [ADDR_W-1:0]        deq_addr_o,
   output logic [1:0]               deq_mask_o,
   input  logic                     deq_ready_i,
   input  logic                     flush_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overflow_o
);

   localparam int unsigned PW       = $clog2(DEPTH);
   localparam int unsigned CW       = PW + 1;
   localparam int unsigned ENTRY_W  = fq_entry_w(DATA_W, ADDR_W);
   localparam int unsigned DATA_LSB = fq_data_lsb();
   localparam int unsigned ADDR_LSB = fq_addr_lsb(DATA_W);
   localparam int unsigned MASK_LSB = fq_mask_lsb(DATA_W, ADDR_W);

   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q,  count_d;
   logic               overflow_q, overflow_d;
   logic               enq_fire, deq_fire, enq_attempt;
   logic [ENTRY_W-1:0] wr_entry, rd_entry;

   // Status is decoded from registered count only, so ready/stall never
   // depend combinationally on decode's handshake.
   assign enq_ready_o = (count_q < CW'(DEPTH));
   assign stall_o     = (count_q >= CW'(DEPTH - 1));
   assign deq_valid_o = (count_q != '0);
   assign count_o     = count_q;
   assign overflow_o  = overflow_q;

   assign enq_attempt = enq_valid_i & ~flush_i & (enq_mask_i != 2'b00);
   assign enq_fire    = enq_attempt & enq_ready_o;
   assign deq_fire    = deq_valid_o & deq_ready_i & ~flush_i;

   always_comb begin
      wr_entry = '0;
      wr_entry[DATA_LSB +: DATA_W] = enq_data_i;
      wr_entry[ADDR_LSB +: ADDR_W] = enq_addr_i;
      wr_entry[MASK_LSB +: 2]      = enq_mask_i;
   end

   fq_storage #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_storage (
      .clock_i (clock_i),
      .we_i    (enq_fire),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_entry),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_entry)
   );

   assign deq_data_o = deq_valid_o ? rd_entry[DATA_LSB +: DATA_W] : '0;
   assign deq_addr_o = deq_valid_o ? rd_entry[ADDR_LSB +: ADDR_W] : '0;
   assign deq_mask_o = deq_valid_o ? rd_entry[MASK_LSB +: 2]      : '0;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (enq_attempt & ~enq_ready_o);
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq_fire) wr_ptr_d = wr_ptr_q + PW'(1);
         if (deq_fire) rd_ptr_d = rd_ptr_q + PW'(1);
         unique case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with hand-computed expectations.
module tb_fetch_queue;

   logic        clock_i = 1'b0;
   logic        reset_ni = 1'b0;
   logic        enq_valid_i = 1'b0;
   logic [63:0] enq_data_i = '0;
   logic [9:0]  enq_addr_i = '0;
   logic [1:0]  enq_mask_i = '0;
   logic        enq_ready_o;
   logic        stall_o;
   logic        deq_valid_o;
   logic [63:0] deq_data_o;
   logic [9:0]  deq_addr_o;
   logic [1:0]  deq_mask_o;
   logic        deq_ready_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [2:0]  count_o;
   logic        overflow_o;

   int unsigned checks = 0;
   int unsigned failures = 0;

   fetch_queue #(.DEPTH(4), .DATA_W(64), .ADDR_W(10)) dut (
      .clock_i     (clock_i),
      .reset_ni    (reset_ni),
      .enq_valid_i (enq_valid_i),
      .enq_data_i  (enq_data_i),
      .enq_addr_i  (enq_addr_i),
      .enq_mask_i  (enq_mask_i),
      .enq_ready_o (enq_ready_o),
      .stall_o     (stall_o),
      .deq_valid_o (deq_valid_o),
      .deq_data_o  (deq_data_o),
      .deq_addr_o  (deq_addr_o),
      .deq_mask_o  (deq_mask_o),
      .deq_ready_i (deq_ready_i),
      .flush_i     (flush_i),
      .count_o     (count_o),
      .overflow_o  (overflow_o)
   );

   always #5 clock_i = ~clock_i;

   function automatic logic [63:0] pkt(input int unsigned a);
      return {32'hB000_0000 | 32'(a), 32'hA000_0000 | 32'(a)};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock_i);
      #1;
   endtask

   task automatic drive_enq(input logic v, input int unsigned a, input logic [1:0] m);
      enq_valid_i = v;
      enq_addr_i  = 10'(a);
      enq_data_i  = pkt(a);
      enq_mask_i  = m;
   endtask

   initial begin
      #2;
      check("rst_count", 64'(count_o), 64'd0);
      check("rst_enq_ready", 64'(enq_ready_o), 64'd1);
      check("rst_stall", 64'(stall_o), 64'd0);
      check("rst_deq_valid", 64'(deq_valid_o), 64'd0);
      check("rst_deq_data", deq_data_o, 64'd0);
      check("rst_overflow", 64'(overflow_o), 64'd0);
      #10 reset_ni = 1'b1;

      // Three enqueues with decode stalled
      for (int i = 0; i < 3; i++) begin
         drive_enq(1'b1, i, 2'b11);
         step();
         check("fill_count", 64'(count_o), 64'(i + 1));
         check("fill_stall", 64'(stall_o), (i == 2) ? 64'd1 : 64'd0);
      end
      check("fill_head_addr", 64'(deq_addr_o), 64'd0);
      check("fill_head_data", deq_data_o, pkt(0));
      check("fill_head_mask", 64'(deq_mask_o), 64'd3);

      // Fill to DEPTH, then a refused enqueue alongside a dequeue
      drive_enq(1'b1, 3, 2'b11);
      step();
      check("full_count", 64'(count_o), 64'd4);
      check("full_enq_ready", 64'(enq_ready_o), 64'd0);
      drive_enq(1'b1, 4, 2'b11);
      deq_ready_i = 1'b1;
      step();
      check("ovf_flag", 64'(overflow_o), 64'd1);
      check("ovf_count", 64'(count_o), 64'd3);
      check("ovf_head_addr", 64'(deq_addr_o), 64'd1);
      drive_enq(1'b0, 0, 2'b00);
      for (int i = 1; i < 4; i++) begin
         check("drain_addr", 64'(deq_addr_o), 64'(i));
         step();
      end
      check("drain_count", 64'(count_o), 64'd0);
      check("drain_valid", 64'(deq_valid_o), 64'd0);
      check("drain_data_zero", deq_data_o, 64'd0);

      // Single-slot packet into an empty queue: no bypass
      deq_ready_i = 1'b0;
      drive_enq(1'b1, 5, 2'b01);
      #1;
      check("nobypass_valid", 64'(deq_valid_o), 64'd0);
      step();
      drive_enq(1'b0, 0, 2'b00);
      check("lat_valid", 64'(deq_valid_o), 64'd1);
      check("lat_mask", 64'(deq_mask_o), 64'd1);
      check("lat_addr", 64'(deq_addr_o), 64'd5);
      check("lat_data", deq_data_o, pkt(5));
      deq_ready_i = 1'b1;
      step();
      check("lat_count_after", 64'(count_o), 64'd0);

      // Streaming enq/deq across pointer wrap
      deq_ready_i = 1'b0;
      drive_enq(1'b1, 0, 2'b11);
      step();
      deq_ready_i = 1'b1;
      for (int i = 1; i < 10; i++) begin
         drive_enq(1'b1, i, 2'b11);
         #1;
         check("stream_addr", 64'(deq_addr_o), 64'(i - 1));
         step();
         check("stream_count", 64'(count_o), 64'd1);
      end
      drive_enq(1'b0, 0, 2'b00);
      check("stream_last_addr", 64'(deq_addr_o), 64'd9);
      step();
      check("stream_end_count", 64'(count_o), 64'd0);

      // Flush with a concurrent enqueue and dequeue
      deq_ready_i = 1'b0;
      drive_enq(1'b1, 20, 2'b11);
      step();
      drive_enq(1'b1, 21, 2'b11);
      step();
      drive_enq(1'b1, 22, 2'b11);
      deq_ready_i = 1'b1;
      flush_i = 1'b1;
      #1;
      check("flush_pre_count", 64'(count_o), 64'd2);
      check("flush_pre_addr", 64'(deq_addr_o), 64'd20);
      step();
      flush_i = 1'b0;
      deq_ready_i = 1'b0;
      check("flush_count", 64'(count_o), 64'd0);
      check("flush_valid", 64'(deq_valid_o), 64'd0);
      drive_enq(1'b1, 30, 2'b10);
      step();
      drive_enq(1'b0, 0, 2'b00);
      check("post_flush_count", 64'(count_o), 64'd1);
      check("post_flush_addr", 64'(deq_addr_o), 64'd30);
      check("post_flush_mask", 64'(deq_mask_o), 64'd2);

      // Async reset clears the sticky overflow
      #2 reset_ni = 1'b0;
      #1;
      check("rst2_overflow", 64'(overflow_o), 64'd0);
      check("rst2_count", 64'(count_o), 64'd0);
      #2 reset_ni = 1'b1;

      // Empty-mask packets are dropped, even when full
      drive_enq(1'b1, 40, 2'b00);
      step();
      check("mask0_count", 64'(count_o), 64'd0);
      check("mask0_overflow", 64'(overflow_o), 64'd0);
      for (int i = 41; i < 45; i++) begin
         drive_enq(1'b1, i, 2'b11);
         step();
      end
      check("refill_count", 64'(count_o), 64'd4);
      drive_enq(1'b1, 45, 2'b00);
      step();
      drive_enq(1'b0, 0, 2'b00);
      check("mask0_full_overflow", 64'(overflow_o), 64'd0);
      check("mask0_full_count", 64'(count_o), 64'd4);
      check("full_head_data", deq_data_o, pkt(41));

      // Mid-cycle reset pulse takes effect immediately
      #2 reset_ni = 1'b0;
      #1;
      check("async_count", 64'(count_o), 64'd0);
      check("async_valid", 64'(deq_valid_o), 64'd0);
      check("async_addr", 64'(deq_addr_o), 64'd0);
      check("async_stall", 64'(stall_o), 64'd0);
      check("async_enq_ready", 64'(enq_ready_o), 64'd1);
      #2 reset_ni = 1'b1;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
